// File: rtl/spi_slv_pkg.sv
// spi_slv_pkg: state/mode encodings and bit-reverse helper shared by the spi_bitrev_slave slice
package spi_slv_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RX   = 2'd1;
  localparam logic [1:0] TX   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} spi_mode_t;
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
    return r;
  endfunction
endpackage

// File: rtl/spi_slv_sync.sv
// spi_slv_sync: multi-flop synchroniser for one asynchronous SPI pin with rise/fall pulses
module spi_slv_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: SPI slave that returns each received word bit-reversed in the same ss frame.
// Define SPI_SLV_CHAIN_EN to keep alternating RX/TX words for as long as ss stays low.
module spi_bitrev_slave
  import spi_slv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam spi_mode_t MODE = spi_mode_t'({CPOL[0], CPHA[0]});
  localparam logic LEAD_RISE = (MODE == MODE0) || (MODE == MODE1);
  localparam logic SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);
  logic sck_s, sck_r, sck_f, ss_s, ss_r, ss_f, mosi_s;
  logic [1:0] mosi_edges_unused;
  logic [1:0] state;
  logic [CW-1:0] bit_cnt;
  logic [WIDTH-2:0] rx_sh;
  logic [WIDTH-1:0] tx_reg, word;
  logic [SW-1:0] settle;
  logic lead, trail, sample, shift, last;
  spi_slv_sync #(.STAGES(SYNC_STAGES)) u_sck (.clock(clock), .resetn(resetn), .d(sck), .q(sck_s), .rise(sck_r), .fall(sck_f));
  spi_slv_sync #(.STAGES(SYNC_STAGES)) u_ss (.clock(clock), .resetn(resetn), .d(ss), .q(ss_s), .rise(ss_r), .fall(ss_f));
  spi_slv_sync #(.STAGES(SYNC_STAGES)) u_mosi (.clock(clock), .resetn(resetn), .d(mosi), .q(mosi_s), .rise(mosi_edges_unused[1]), .fall(mosi_edges_unused[0]));
  assign lead   = LEAD_RISE ? sck_r : sck_f;
  assign trail  = LEAD_RISE ? sck_f : sck_r;
  assign sample = SAMPLE_LEAD ? lead : trail;
  assign shift  = SAMPLE_LEAD ? trail : lead;
  assign last   = bit_cnt == CW'(WIDTH - 1);
  assign word   = {rx_sh, mosi_s};
  assign busy   = state != IDLE;
  // settle counts out the synchroniser fill after reset so a still-low ss is seen reliably
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state    <= IDLE;
      miso     <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_reg   <= '0;
      settle   <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (settle != SW'(SYNC_STAGES + 1)) settle <= settle + 1'b1;
      if (state != IDLE && ss_r) begin
        state <= IDLE;
        miso  <= 1'b1;
      end else
        case (state)
          IDLE: begin
            miso <= 1'b1;
            if (ss_f) begin
              state   <= RX;
              bit_cnt <= '0;
              rx_sh   <= '0;
              miso    <= 1'b0;
            end else if (settle == SW'(SYNC_STAGES) && !ss_s)
              state <= DONE;
          end
          RX: begin
            miso <= 1'b0;
            if (sample) begin
              rx_sh   <= word[WIDTH-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (last) begin
                rx_data  <= word;
                tx_reg   <= WIDTH'(bitrev(32'(word), WIDTH));
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                state    <= TX;
              end
            end
          end
          TX:
            if (shift)
              miso <= tx_reg[CW'(WIDTH - 1) - bit_cnt];
            else if (sample) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (last) begin
                bit_cnt <= '0;
`ifdef SPI_SLV_CHAIN_EN
                state <= RX;
                rx_sh <= '0;
                miso  <= 1'b0;
`else
                state <= DONE;
                miso  <= 1'b1;
`endif
              end
            end
          default: miso <= 1'b1;
        endcase
    end
endmodule

// File: doc/spi_bitrev_slave.md
Name: spi_bitrev_slave

Overview:
- Parametrised SPI slave test peripheral that receives a WIDTH-bit word MSB-first on mosi, then returns its bit-reversed value MSB-first on miso within the same ss-low frame.
- Successor to the fixed 8-bit, sck-clocked bit-reverser. Runs in the system clock domain with synchronised SPI inputs and supports all four CPOL/CPHA modes.
- Sits on the SoC SPI bus as a loopback target for SPI master driver and controller tests.

Parameters:
- WIDTH, 8, word length in bits (2..32).
- CPOL, 0, sck idle level.
- CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
- SYNC_STAGES, 2, flop stages on sck, ss and mosi (at least 2).

Ports:
- clock  in  1  system clock; must run at ≥ 4× sck frequency.
- resetn  in  1  asynchronous reset, active low.
- sck  in  1  SPI clock (asynchronous).
- ss  in  1  slave select, active low (asynchronous).
- mosi  in  1  master-out data (asynchronous).
- miso  out  1  slave-out data, registered.
- rx_data  out  WIDTH  last fully received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (async, resetn=0): state=IDLE, miso=1, rx_data=0, rx_valid=0, busy=0, all counters and shift registers 0.
- Input handling:
  - sck, ss and mosi each pass through SYNC_STAGES flops.
  - Edge detect on synced sck gives lead/trail edge pulses.
  - Sample edge = lead if CPHA=0, else trail. Shift edge = the other edge.
  - Lead edge = rising if CPOL=0, else falling.
- IDLE:
  - miso=1; all sck edges ignored.
  - Synced ss falling → RX, with bit_cnt=0 and rx_sh=0.
- RX:
  - miso=0.
  - Each sample edge: rx_sh <= {rx_sh[WIDTH-2:0], mosi_s}; bit_cnt++.
  - On the sample edge where bit_cnt==WIDTH-1:
    - rx_data <= {rx_sh, mosi_s}.
    - tx_reg <= bit-reverse of {rx_sh, mosi_s}.
    - rx_valid pulses on the next clock cycle.
    - bit_cnt <= 0; go to TX.
- TX:
  - Each shift edge: miso <= tx_reg[WIDTH-1-bit_cnt].
  - Each sample edge: bit_cnt++.
  - On the WIDTH-th sample edge → DONE.
- DONE:
  - miso=1; sck edges ignored until synced ss rises, then → IDLE.
- ss rising in any state:
  - → IDLE next cycle; miso=1.
  - A partial RX word is discarded (no rx_valid); a partial TX is aborted.
- Simultaneous ss rise and sample edge in the same cycle: ss wins; the edge is ignored.
- Reset mid-frame: on release, if synced ss is still low, enter DONE (wait for ss high). Never resume mid-frame.
- End-to-end latency: first reversed bit is valid on miso within SYNC_STAGES+2 clock cycles of the first TX-phase shift edge at the pin.
- rx_data holds its value until the next complete word.

Optional Feature:
- Macro SPI_SLV_CHAIN_EN.
- Defined: after the WIDTH-th TX sample edge with ss still low, go to RX (bit_cnt=0) instead of DONE. Alternating receive/return frames continue until ss rises; each received word pulses rx_valid.
- Undefined: behaviour exactly as above; a single RX/TX pair per ss assertion.

Decomposition:
- Package spi_slv_pkg:
  - state enum {IDLE, RX, TX, DONE}.
  - mode encoding constants (MODE0..MODE3 as {CPOL,CPHA}).
  - parametric bit-reverse function.
- Sub-module spi_slv_sync (one instance per input):
  - synchroniser chain, plus rise/fall pulse outputs for sck.
  - Top level holds the FSM, counters and shift registers.

Test Plan:
- WIDTH=8, mode 0, send 0xB1 then 8 dummy clocks → rx_data=0xB1, single rx_valid pulse, miso returns 0x8D, miso=0 during RX, miso=1 after ss high.
- WIDTH=8, modes 1/2/3, send 0x01 → miso returns 0x80 in each mode; bits are stable around every master sample edge.
- WIDTH=16, send 0x1234 → return 0x2C48; busy high from ss fall until 2 cycles after ss rise.
- Abort: ss rises after 5 of 8 RX bits, then a new frame sends 0xF0 → no rx_valid for the aborted frame; second frame returns 0x0F.
- Reset asserted mid-TX with ss held low → miso=1 immediately; after release, sck ignored until ss toggles; the next frame sending 0x3C returns 0x3C.
- SPI_SLV_CHAIN_EN defined, one ss assertion sending 0xA0, 8 dummy bits, then 0x03, 8 dummy bits → two rx_valid pulses, miso returns 0x05 then 0xC0. With the macro undefined, the second word is ignored and miso=1.
